// File: rtl/alarm_timekeeper_if.sv
// Control inputs and display/ring outputs of the alarm timekeeper.
// The bench drives the master side; the timekeeper is the slave.
interface alarm_timekeeper_if;
    logic       tick;
    logic       set_time;
    logic       set_alarm;
    logic       inc_min;
    logic       inc_hour;
    logic       alarm_en;
    logic       stop;
    logic [6:0] cur_hour;
    logic [6:0] cur_min;
    logic [5:0] cur_sec;
    logic [6:0] alm_hour;
    logic [6:0] alm_min;
    logic       show_alarm;
    logic       alarm_ring;

    modport master (
        output tick, set_time, set_alarm, inc_min, inc_hour, alarm_en, stop,
        input  cur_hour, cur_min, cur_sec, alm_hour, alm_min, show_alarm, alarm_ring
    );

    modport slave (
        input  tick, set_time, set_alarm, inc_min, inc_hour, alarm_en, stop,
        output cur_hour, cur_min, cur_sec, alm_hour, alm_min, show_alarm, alarm_ring
    );
endinterface

// File: rtl/alarm_timekeeper.sv
// Time-of-day counter and alarm registers with button-driven set modes.
// The ring output is held for RING_SECONDS ticks unless it is silenced earlier.
module alarm_timekeeper #(
    parameter int RING_SECONDS   = 60,
    parameter int ALARM_RST_HOUR = 7,
    parameter int ALARM_RST_MIN  = 0
) (
    input  logic              clk,
    input  logic              rst,
    alarm_timekeeper_if.slave bus
);
    localparam logic [1:0] MODE_RUN       = 2'd0;
    localparam logic [1:0] MODE_SET_TIME  = 2'd1;
    localparam logic [1:0] MODE_SET_ALARM = 2'd2;

    logic [6:0] cur_hour_q, cur_hour_d;
    logic [6:0] cur_min_q, cur_min_d;
    logic [5:0] cur_sec_q, cur_sec_d;
    logic [6:0] alm_hour_q, alm_hour_d;
    logic [6:0] alm_min_q, alm_min_d;
    logic [1:0] mode_q, mode_d;
    logic       ring_q, ring_d;
    logic [6:0] ring_cnt_q, ring_cnt_d;
    logic       inc_min_prev_q, inc_min_prev_d;
    logic       inc_hour_prev_q, inc_hour_prev_d;
    logic       min_edge, hour_edge, match, ring_clear;

    always_comb begin
        mode_d = MODE_RUN;
        if (bus.set_time)
            mode_d = MODE_SET_TIME;
        else if (bus.set_alarm)
            mode_d = MODE_SET_ALARM;

        min_edge        = bus.inc_min & ~inc_min_prev_q;
        hour_edge       = bus.inc_hour & ~inc_hour_prev_q;
        inc_min_prev_d  = bus.inc_min;
        inc_hour_prev_d = bus.inc_hour;

        cur_hour_d = cur_hour_q;
        cur_min_d  = cur_min_q;
        cur_sec_d  = cur_sec_q;
        alm_hour_d = alm_hour_q;
        alm_min_d  = alm_min_q;

        if (mode_d == MODE_SET_TIME) begin
            cur_sec_d = 6'd0;
            if (min_edge)
                cur_min_d = (cur_min_q == 7'd59) ? 7'd0 : cur_min_q + 7'd1;
            if (hour_edge)
                cur_hour_d = (cur_hour_q == 7'd23) ? 7'd0 : cur_hour_q + 7'd1;
        end else begin
            if (bus.tick) begin
                if (cur_sec_q != 6'd59) begin
                    cur_sec_d = cur_sec_q + 6'd1;
                end else begin
                    cur_sec_d = 6'd0;
                    if (cur_min_q != 7'd59) begin
                        cur_min_d = cur_min_q + 7'd1;
                    end else begin
                        cur_min_d  = 7'd0;
                        cur_hour_d = (cur_hour_q == 7'd23) ? 7'd0 : cur_hour_q + 7'd1;
                    end
                end
            end
            if (mode_d == MODE_SET_ALARM) begin
                if (min_edge)
                    alm_min_d = (alm_min_q == 7'd59) ? 7'd0 : alm_min_q + 7'd1;
                if (hour_edge)
                    alm_hour_d = (alm_hour_q == 7'd23) ? 7'd0 : alm_hour_q + 7'd1;
            end
        end

        // Match looks at the next-state time so midnight alarms fire on the wrap tick.
        match = bus.tick && (mode_d != MODE_SET_TIME) && bus.alarm_en &&
                (cur_sec_d == 6'd0) && (cur_min_d == alm_min_q) &&
                (cur_hour_d == alm_hour_q);
        ring_clear = bus.stop || !bus.alarm_en || (mode_d == MODE_SET_TIME);

        ring_d     = ring_q;
        ring_cnt_d = ring_cnt_q;
        if (ring_clear) begin
            ring_d     = 1'b0;
            ring_cnt_d = 7'd0;
        end else if (match) begin
            ring_d     = 1'b1;
            ring_cnt_d = 7'(RING_SECONDS);
        end else if (ring_q && bus.tick && (ring_cnt_q != 7'd0)) begin
            ring_cnt_d = ring_cnt_q - 7'd1;
            if (ring_cnt_q == 7'd1)
                ring_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_hour_q      <= 7'd0;
            cur_min_q       <= 7'd0;
            cur_sec_q       <= 6'd0;
            alm_hour_q      <= 7'(ALARM_RST_HOUR);
            alm_min_q       <= 7'(ALARM_RST_MIN);
            mode_q          <= MODE_RUN;
            ring_q          <= 1'b0;
            ring_cnt_q      <= 7'd0;
            inc_min_prev_q  <= 1'b0;
            inc_hour_prev_q <= 1'b0;
        end else begin
            cur_hour_q      <= cur_hour_d;
            cur_min_q       <= cur_min_d;
            cur_sec_q       <= cur_sec_d;
            alm_hour_q      <= alm_hour_d;
            alm_min_q       <= alm_min_d;
            mode_q          <= mode_d;
            ring_q          <= ring_d;
            ring_cnt_q      <= ring_cnt_d;
            inc_min_prev_q  <= inc_min_prev_d;
            inc_hour_prev_q <= inc_hour_prev_d;
        end
    end

    assign bus.cur_hour   = cur_hour_q;
    assign bus.cur_min    = cur_min_q;
    assign bus.cur_sec    = cur_sec_q;
    assign bus.alm_hour   = alm_hour_q;
    assign bus.alm_min    = alm_min_q;
    assign bus.show_alarm = (mode_q == MODE_SET_ALARM);
    assign bus.alarm_ring = ring_q;
endmodule

// File: tb/tb_alarm_timekeeper.sv
// Bench for alarm_timekeeper: a table of single-cycle vectors plus
// hand-written sequences for counting, setting and ringing.
module tb_alarm_timekeeper;
    typedef struct {
        string      name;
        logic [6:0] h;
        logic [6:0] m;
        logic [5:0] s;
        logic [6:0] ah;
        logic [6:0] am;
        logic       sa;
        logic       ring;
    } exp_t;

    typedef struct {
        logic st, sal, im, ih, tk;
        exp_t e;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;
    exp_t sbQ[$];
    vec_t vecs[10];

    alarm_timekeeper_if bus ();

    alarm_timekeeper #(
        .RING_SECONDS  (60),
        .ALARM_RST_HOUR(7),
        .ALARM_RST_MIN (0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic exp_t mk(string n, int h, int m, int s, int ah, int am, int sa, int rg);
        exp_t e;
        e.name = n;
        e.h = 7'(h);
        e.m = 7'(m);
        e.s = 6'(s);
        e.ah = 7'(ah);
        e.am = 7'(am);
        e.sa = 1'(sa);
        e.ring = 1'(rg);
        return e;
    endfunction

    task automatic checkField(input string n, input string f, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("[TB] FAIL %s.%s actual=%0d required=%0d", n, f, act, req);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sbQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard actual=empty required=entry");
            return;
        end
        e = sbQ.pop_front();
        checkField(e.name, "cur_hour", int'(bus.cur_hour), int'(e.h));
        checkField(e.name, "cur_min", int'(bus.cur_min), int'(e.m));
        checkField(e.name, "cur_sec", int'(bus.cur_sec), int'(e.s));
        checkField(e.name, "alm_hour", int'(bus.alm_hour), int'(e.ah));
        checkField(e.name, "alm_min", int'(bus.alm_min), int'(e.am));
        checkField(e.name, "show_alarm", int'(bus.show_alarm), int'(e.sa));
        checkField(e.name, "alarm_ring", int'(bus.alarm_ring), int'(e.ring));
    endtask

    task automatic expectNow(input exp_t e);
        sbQ.push_back(e);
        checkOutput();
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.set_time  = v.st;
        bus.set_alarm = v.sal;
        bus.inc_min   = v.im;
        bus.inc_hour  = v.ih;
        bus.tick      = v.tk;
        sbQ.push_back(v.e);
        @(negedge clk);
        bus.tick = 1'b0;
        checkOutput();
    endtask

    task automatic doReset();
        bus.tick = 0; bus.set_time = 0; bus.set_alarm = 0;
        bus.inc_min = 0; bus.inc_hour = 0; bus.stop = 0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic doTicks(input int n);
        repeat (n) begin
            bus.tick = 1'b1;
            @(negedge clk);
            bus.tick = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic pressMin(input int n);
        repeat (n) begin
            bus.inc_min = 1'b1;
            @(negedge clk);
            bus.inc_min = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic pressHour(input int n);
        repeat (n) begin
            bus.inc_hour = 1'b1;
            @(negedge clk);
            bus.inc_hour = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic bumpAlarmMin();
        bus.set_alarm = 1'b1;
        pressMin(1);
        bus.set_alarm = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        // {set_time, set_alarm, inc_min, inc_hour, tick} -> state after the cycle
        vecs[0] = '{0, 0, 0, 0, 1, mk("v0_run_tick",      0, 0, 1, 7, 0, 0, 0)};
        vecs[1] = '{0, 0, 1, 0, 0, mk("v1_run_btn_ign",   0, 0, 1, 7, 0, 0, 0)};
        vecs[2] = '{0, 0, 0, 0, 0, mk("v2_run_idle",      0, 0, 1, 7, 0, 0, 0)};
        vecs[3] = '{0, 1, 0, 1, 1, mk("v3_salm_tick_hr",  0, 0, 2, 8, 0, 1, 0)};
        vecs[4] = '{0, 1, 0, 1, 0, mk("v4_salm_held",     0, 0, 2, 8, 0, 1, 0)};
        vecs[5] = '{0, 1, 1, 0, 0, mk("v5_salm_min",      0, 0, 2, 8, 1, 1, 0)};
        vecs[6] = '{0, 1, 0, 0, 0, mk("v6_salm_idle",     0, 0, 2, 8, 1, 1, 0)};
        vecs[7] = '{1, 1, 1, 1, 1, mk("v7_stime_both",    1, 1, 0, 8, 1, 0, 0)};
        vecs[8] = '{1, 0, 0, 0, 1, mk("v8_stime_frozen",  1, 1, 0, 8, 1, 0, 0)};
        vecs[9] = '{0, 0, 0, 0, 1, mk("v9_run_again",     1, 1, 1, 8, 1, 0, 0)};

        bus.alarm_en = 1'b0;
        @(negedge clk);
        bus.tick = 0; bus.set_time = 0; bus.set_alarm = 0;
        bus.inc_min = 0; bus.inc_hour = 0; bus.stop = 0;
        rst = 1'b1;
        @(negedge clk);
        expectNow(mk("reset_hold", 0, 0, 0, 7, 0, 0, 0));
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++)
            applyStimulus(vecs[i]);

        // Long run through an hour and minute carry.
        doReset();
        doTicks(3661);
        expectNow(mk("run_3661", 1, 1, 1, 7, 0, 0, 0));

        // Set 23:59, including a long hold that must count once.
        doReset();
        bus.set_time = 1'b1;
        bus.inc_min = 1'b1;
        repeat (100) @(negedge clk);
        expectNow(mk("hold_single_inc", 0, 1, 0, 7, 0, 0, 0));
        bus.inc_min = 1'b0;
        @(negedge clk);
        pressHour(23);
        pressMin(58);
        expectNow(mk("set_2359", 23, 59, 0, 7, 0, 0, 0));
        bus.set_time = 1'b0;
        doTicks(59);
        expectNow(mk("at_235959", 23, 59, 59, 7, 0, 0, 0));
        doTicks(1);
        expectNow(mk("midnight_wrap", 0, 0, 0, 7, 0, 0, 0));

        // Minute wrap in SET_TIME does not carry, and ticks are frozen.
        bus.set_time = 1'b1;
        pressHour(10);
        pressMin(59);
        bus.set_time = 1'b0;
        doTicks(30);
        expectNow(mk("at_105930", 10, 59, 30, 7, 0, 0, 0));
        bus.set_time = 1'b1;
        bus.inc_min = 1'b1;
        @(negedge clk);
        bus.inc_min = 1'b0;
        expectNow(mk("min_wrap_nocarry", 10, 0, 0, 7, 0, 0, 0));
        doTicks(5);
        expectNow(mk("stime_ticks_frozen", 10, 0, 0, 7, 0, 0, 0));
        bus.set_time = 1'b0;

        // Alarm at the reset value 07:00 and auto-stop after 60 ticks.
        doReset();
        bus.set_time = 1'b1;
        pressHour(6);
        pressMin(59);
        bus.set_time = 1'b0;
        bus.alarm_en = 1'b1;
        doTicks(58);
        expectNow(mk("at_065958", 6, 59, 58, 7, 0, 0, 0));
        doTicks(1);
        expectNow(mk("at_065959", 6, 59, 59, 7, 0, 0, 0));
        bus.tick = 1'b1;
        @(negedge clk);
        bus.tick = 1'b0;
        expectNow(mk("ring_rise", 7, 0, 0, 7, 0, 0, 1));
        @(negedge clk);
        doTicks(59);
        expectNow(mk("ring_59", 7, 0, 59, 7, 0, 0, 1));
        doTicks(1);
        expectNow(mk("ring_auto_stop", 7, 1, 0, 7, 0, 0, 0));

        // Silence by stop.
        bumpAlarmMin();
        bumpAlarmMin();
        expectNow(mk("alarm_0702", 7, 1, 0, 7, 2, 0, 0));
        doTicks(60);
        expectNow(mk("ring_0702", 7, 2, 0, 7, 2, 0, 1));
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        expectNow(mk("stop_clears", 7, 2, 0, 7, 2, 0, 0));

        // Silence by disarming.
        bumpAlarmMin();
        doTicks(60);
        expectNow(mk("ring_0703", 7, 3, 0, 7, 3, 0, 1));
        bus.alarm_en = 1'b0;
        @(negedge clk);
        expectNow(mk("disarm_clears", 7, 3, 0, 7, 3, 0, 0));
        bus.alarm_en = 1'b1;
        @(negedge clk);

        // Silence by entering SET_TIME.
        bumpAlarmMin();
        doTicks(60);
        expectNow(mk("ring_0704", 7, 4, 0, 7, 4, 0, 1));
        bus.set_time = 1'b1;
        @(negedge clk);
        bus.set_time = 1'b0;
        expectNow(mk("settime_clears", 7, 4, 0, 7, 4, 0, 0));
        @(negedge clk);

        // Silence by reset; ringing must not come back.
        bumpAlarmMin();
        doTicks(60);
        expectNow(mk("ring_0705", 7, 5, 0, 7, 5, 0, 1));
        rst = 1'b1;
        #1;
        expectNow(mk("reset_mid_ring", 0, 0, 0, 7, 0, 0, 0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        doTicks(2);
        expectNow(mk("after_reset_quiet", 0, 0, 2, 7, 0, 0, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
